// File: rtl/solo_squash_pkg.sv
// ----------------------------------------------------------------------------
// solo_squash_pkg
// Shared definitions for the solo_squash board wrapper and input conditioning.
//   state_e             : per-channel debounce FSM state encoding
//   DEBOUNCE_10MS_25MHZ : cycles in 10 ms at a 25 MHz pixel clock
// ----------------------------------------------------------------------------
package solo_squash_pkg;

    typedef enum logic [1:0] {
        REL   = 2'd0,   // stable released
        PWAIT = 2'd1,   // press pending
        PRS   = 2'd2,   // stable pressed
        RWAIT = 2'd3    // release pending
    } state_e;

    localparam int unsigned DEBOUNCE_10MS_25MHZ = 250000;

endpackage

// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the button-side signals of button_conditioner.
//   i_btn_raw_n : raw asynchronous pins, 0 = pressed (driven by board side)
//   o_btn_n     : debounced level, 0 = pressed
//   o_press     : one-cycle pulse on debounced falling level
//   o_release   : one-cycle pulse on debounced rising level
// Modports: master = board/game side, slave = conditioner.
// ----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int unsigned NUM_BTNS = 5
);
    logic [NUM_BTNS-1:0] i_btn_raw_n;
    logic [NUM_BTNS-1:0] o_btn_n;
    logic [NUM_BTNS-1:0] o_press;
    logic [NUM_BTNS-1:0] o_release;

    modport master (
        output i_btn_raw_n,
        input  o_btn_n,
        input  o_press,
        input  o_release
    );

    modport slave (
        input  i_btn_raw_n,
        output o_btn_n,
        output o_press,
        output o_release
    );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// Single-bit synchroniser + debounce FSM + press/release pulse generation.
//   clk       : pixel clock
//   reset     : synchronous, active-high
//   i_raw_n   : raw asynchronous pin, 0 = pressed
//   o_btn_n   : debounced registered level, 0 = pressed
//   o_press   : one-cycle pulse coincident with o_btn_n falling
//   o_release : one-cycle pulse coincident with o_btn_n rising
// ----------------------------------------------------------------------------
module debounce_channel
    import solo_squash_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw_n,
    output logic o_btn_n,
    output logic o_press,
    output logic o_release
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_btn_n;
    logic                   r_press;
    logic                   r_release;

    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_btn_n_nxt;
    logic                   w_press_nxt;
    logic                   w_release_nxt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '1;
            r_state   <= REL;
            r_cnt     <= '0;
            r_btn_n   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw_n};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_btn_n   <= w_btn_n_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Counter only increments below CntMax, so it cannot wrap.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_btn_n_nxt   = r_btn_n;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        unique case (r_state)
            REL: begin
                if (!w_sync) begin
                    w_state_nxt = PWAIT;
                    w_cnt_nxt   = CntOne;
                end
            end
            PWAIT: begin
                if (w_sync) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CntMax) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                    w_btn_n_nxt = 1'b0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRS: begin
                if (w_sync) begin
                    w_state_nxt = RWAIT;
                    w_cnt_nxt   = CntOne;
                end
            end
            RWAIT: begin
                if (!w_sync) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CntMax) begin
                    w_state_nxt   = REL;
                    w_cnt_nxt     = '0;
                    w_btn_n_nxt   = 1'b1;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_btn_n   = r_btn_n;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Multi-channel pushbutton synchroniser/debouncer for the solo_squash core.
//   clk   : pixel clock
//   reset : synchronous, active-high
//   bus   : button_conditioner_if.slave (raw pins in; level and pulses out)
// Each channel is an independent debounce_channel; no logic is shared.
// ----------------------------------------------------------------------------
module button_conditioner
    import solo_squash_pkg::*;
#(
    parameter int unsigned NUM_BTNS        = 5,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);
    logic [NUM_BTNS-1:0] w_btn_n;
    logic [NUM_BTNS-1:0] w_press;
    logic [NUM_BTNS-1:0] w_release;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_raw_n   (bus.i_btn_raw_n[g]),
            .o_btn_n   (w_btn_n[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g])
        );
    end

    assign bus.o_btn_n   = w_btn_n;
    assign bus.o_press   = w_press;
    assign bus.o_release = w_release;
endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
// Directed bench for button_conditioner with NUM_BTNS=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, so a clean raw edge reaches btn_n after 10 edges.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_button_conditioner;
    localparam int unsigned NB = 2;

    typedef struct {
        logic          rst;
        logic [NB-1:0] raw;
        logic [NB-1:0] btn_n;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        string         name;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    button_conditioner_if #(.NUM_BTNS(NB)) bus ();

    button_conditioner #(
        .NUM_BTNS        (NB),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic [NB-1:0] raw,
                                input logic [NB-1:0] b, input logic [NB-1:0] p,
                                input logic [NB-1:0] r, input string nm);
        vec_t v;
        v.rst = rst; v.raw = raw; v.btn_n = b; v.press = p; v.rel = r; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock once, compare all outputs.
    task automatic cyc(input logic rst, input logic [NB-1:0] raw, input logic [NB-1:0] b,
                       input logic [NB-1:0] p, input logic [NB-1:0] r, input string nm);
        reset           = rst;
        bus.i_btn_raw_n = raw;
        @(posedge clk);
        #1;
        chk({nm, ".btn_n"},   bus.o_btn_n,   b);
        chk({nm, ".press"},   bus.o_press,   p);
        chk({nm, ".release"}, bus.o_release, r);
    endtask

    initial begin
        bus.i_btn_raw_n = 2'b11;

        // Vector table: reset, stable idle, clean press on channel 0.
        for (int i = 0; i < 3; i++)  add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, "reset");
        for (int i = 0; i < 50; i++) add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, "idle");
        for (int i = 1; i < 10; i++) add(1'b0, 2'b10, 2'b11, 2'b00, 2'b00, "press_wait");
        add(1'b0, 2'b10, 2'b10, 2'b01, 2'b00, "press_edge10");
        for (int i = 0; i < 3; i++)  add(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, "press_hold");

        foreach (vecs[i]) cyc(vecs[i].rst, vecs[i].raw, vecs[i].btn_n, vecs[i].press,
                              vecs[i].rel, vecs[i].name);

        // Release of channel 0 with a one-cycle dip on the 4th cycle: the dip
        // restarts the count, pushing acceptance from edge 10 to edge 14.
        for (int e = 1; e <= 13; e++)
            cyc(1'b0, (e == 4) ? 2'b10 : 2'b11, 2'b10, 2'b00, 2'b00, "rel_dip_wait");
        cyc(1'b0, 2'b11, 2'b11, 2'b00, 2'b01, "rel_dip_edge14");
        cyc(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, "rel_dip_after");

        // Bounce: 3 low / 3 high on channel 0, never long enough to accept.
        for (int c = 0; c < 60; c++)
            cyc(1'b0, ((c % 6) < 3) ? 2'b10 : 2'b11, 2'b11, 2'b00, 2'b00, "bounce");
        for (int c = 0; c < 20; c++)
            cyc(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, "bounce_settle");

        // Channel 1 held low; reset after 5 synced-low cycles abandons PWAIT.
        for (int e = 1; e <= 6; e++)
            cyc(1'b0, 2'b01, 2'b11, 2'b00, 2'b00, "pwait_pre");
        cyc(1'b1, 2'b01, 2'b11, 2'b00, 2'b00, "pwait_reset");
        for (int e = 1; e <= 9; e++)
            cyc(1'b0, 2'b01, 2'b11, 2'b00, 2'b00, "pwait_post_wait");
        cyc(1'b0, 2'b01, 2'b01, 2'b10, 2'b00, "pwait_post_edge10");
        cyc(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, "pwait_post_hold");

        // Clean release of channel 1.
        for (int e = 1; e <= 9; e++)
            cyc(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, "rel1_wait");
        cyc(1'b0, 2'b11, 2'b11, 2'b00, 2'b10, "rel1_edge10");
        cyc(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, "rel1_after");

        // Both channels pressed on the same edge.
        for (int e = 1; e <= 9; e++)
            cyc(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, "simul_wait");
        cyc(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, "simul_edge10");
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "simul_hold");

        // Reset while pressed: level returns to released with no release pulse,
        // then the still-held buttons are accepted as a fresh press.
        cyc(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, "prs_reset");
        for (int e = 1; e <= 9; e++)
            cyc(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, "held_wait");
        cyc(1'b0, 2'b00, 2'b00, 2'b11, 2'b00, "held_edge10");
        cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, "held_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
